// File: rtl/dmem_write_buffer_if.sv
// Block-granular data memory bus: the cache side of the write buffer and the
// memory side use the same signal set, so one interface serves both.
interface dmem_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) ();
  logic              READ;
  logic              WRITE;
  logic [ADDR_W-1:0] ADDRESS;
  logic [DATA_W-1:0] WRITEDATA;
  logic [DATA_W-1:0] READDATA;
  logic              BUSYWAIT;

  modport master (output READ, WRITE, ADDRESS, WRITEDATA, input READDATA, BUSYWAIT);
  modport slave  (input READ, WRITE, ADDRESS, WRITEDATA, output READDATA, BUSYWAIT);
endinterface

// File: rtl/dmem_write_buffer.sv
// Posted write buffer between data cache and data memory: coalescing FIFO of
// block writes, read forwarding from queued entries, and read-miss bypass.
module dmem_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic   CLK,
  input  logic   RESET,
  dmem_if.slave  cache_bus,
  dmem_if.master mem_bus,
  output logic   BUF_EMPTY
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_READ, S_RDONE} state_t;

  state_t                        state, state_nxt;
  logic [DEPTH-1:0]              ent_vld;
  logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0]  ent_data;
  logic [PTR_W-1:0]              head, tail;
  logic [CNT_W-1:0]              count;
  logic [DATA_W-1:0]             fill_data;
  logic                          m_read_q, m_write_q;
  logic [ADDR_W-1:0]             m_addr_q;
  logic [DATA_W-1:0]             m_wdata_q;

  logic [DEPTH-1:0] addr_hit, in_flight, coal_hit;
  logic             coal_any, rd_any, full;
  logic [PTR_W-1:0] coal_idx, rd_idx, wr_idx;
  logic             wr_acc, wr_enq, rd_req, rd_pend;
  logic             drain_done, read_done, head_fwd;
  logic             c_busy;

  // Per-entry address compare; the head is untouchable while it is on the memory bus
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign addr_hit[i]  = ent_vld[i] && (ent_addr[i] == cache_bus.ADDRESS);
    assign in_flight[i] = (state == S_DRAIN) && (head == PTR_W'(i));
  end
  assign coal_hit = addr_hit & ~in_flight;

  always_comb begin
    coal_any = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (coal_hit[i]) begin
        coal_any = 1'b1;
        coal_idx = PTR_W'(i);
      end
  end

  // A read can hit both the in-flight head and a newer copy; the newer one wins
  assign rd_any     = |addr_hit;
  assign rd_idx     = coal_any ? coal_idx : head;
  assign full       = (count == CNT_W'(DEPTH));
  assign wr_acc     = cache_bus.WRITE && (coal_any || !full);
  assign wr_enq     = wr_acc && !coal_any;
  assign wr_idx     = coal_any ? coal_idx : tail;
  assign rd_req     = cache_bus.READ && !cache_bus.WRITE;
  assign rd_pend    = rd_req && !rd_any;
  assign drain_done = (state == S_DRAIN) && !mem_bus.BUSYWAIT;
  assign read_done  = (state == S_READ) && !mem_bus.BUSYWAIT;
  assign head_fwd   = wr_acc && coal_any && (coal_idx == head);

  always_comb begin
    c_busy = 1'b0;
    if (cache_bus.WRITE)     c_busy = !wr_acc;
    else if (cache_bus.READ) c_busy = !(rd_any || state == S_RDONE);
  end

  assign cache_bus.BUSYWAIT = c_busy;
  assign cache_bus.READDATA = (cache_bus.READ && rd_any) ? ent_data[rd_idx] : fill_data;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (rd_pend)             state_nxt = S_READ;
        else if (count != '0)    state_nxt = S_DRAIN;
      end
      S_DRAIN: if (drain_done)   state_nxt = S_IDLE;
      S_READ:  if (read_done)    state_nxt = S_RDONE;
      S_RDONE:                   state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ent_vld   <= '0;
      ent_addr  <= '0;
      ent_data  <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      fill_data <= '0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      if (wr_acc) begin
        ent_vld[wr_idx]  <= 1'b1;
        ent_addr[wr_idx] <= cache_bus.ADDRESS;
        ent_data[wr_idx] <= cache_bus.WRITEDATA;
      end
      if (wr_enq) tail <= tail + 1'b1;
      if (drain_done) begin
        ent_vld[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      case ({wr_enq, drain_done})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Launching a drain while the cache coalesces into that same head entry
      // must carry the new data, or the overwrite would be lost
      if (state == S_IDLE && state_nxt == S_DRAIN) begin
        m_write_q <= 1'b1;
        m_addr_q  <= ent_addr[head];
        m_wdata_q <= head_fwd ? cache_bus.WRITEDATA : ent_data[head];
      end else if (drain_done) begin
        m_write_q <= 1'b0;
      end

      if (state == S_IDLE && state_nxt == S_READ) begin
        m_read_q <= 1'b1;
        m_addr_q <= cache_bus.ADDRESS;
      end else if (read_done) begin
        m_read_q  <= 1'b0;
        fill_data <= mem_bus.READDATA;
      end
    end
  end

  assign mem_bus.READ      = m_read_q;
  assign mem_bus.WRITE     = m_write_q;
  assign mem_bus.ADDRESS   = m_addr_q;
  assign mem_bus.WRITEDATA = m_wdata_q;
  assign BUF_EMPTY         = (count == '0) && (state != S_DRAIN);
endmodule

// File: tb/tb_dmem_write_buffer.sv
// Scenario bench for dmem_write_buffer with a variable-latency memory model
// and a scoreboard of expected memory writes.
module tb_dmem_write_buffer;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  logic BUF_EMPTY;

  dmem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cbus ();
  dmem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mbus ();

  dmem_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .RESET(RESET), .cache_bus(cbus), .mem_bus(mbus), .BUF_EMPTY(BUF_EMPTY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_count = 0;
  int lat_cnt = 0;
  int mem_lat = 2;
  bit force_busy = 1'b0;
  logic [37:0] exp_wr[$];
  logic [31:0] exp_rd[$];
  int done_cyc[$];
  logic [37:0] mon_exp;

  // Memory: stalls a request for mem_lat cycles, or indefinitely while force_busy
  assign mbus.BUSYWAIT = (mbus.READ || mbus.WRITE) && (force_busy || lat_cnt < mem_lat);
  assign mbus.READDATA = {2{mbus.ADDRESS, 10'h35A}};

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!RESET) lat_cnt <= 0;
    else if ((mbus.READ || mbus.WRITE) && !mbus.BUSYWAIT) begin
      lat_cnt <= 0;
      if (mbus.WRITE) begin
        wr_count <= wr_count + 1;
        done_cyc.push_back(cyc + 1);
      end
    end else if (mbus.READ || mbus.WRITE) lat_cnt <= lat_cnt + 1;
  end

  always @(posedge CLK) begin
    if (RESET && mbus.WRITE && !mbus.BUSYWAIT) begin
      checks++;
      if (exp_wr.size() == 0) begin
        failures++;
        $display("FAIL mem_write_unexpected: got addr=%h data=%h, none expected", mbus.ADDRESS, mbus.WRITEDATA);
      end else begin
        mon_exp = exp_wr.pop_front();
        if ({mbus.ADDRESS, mbus.WRITEDATA} !== mon_exp) begin
          failures++;
          $display("FAIL mem_write_order: got %h_%h expected %h_%h",
                   mbus.ADDRESS, mbus.WRITEDATA, mon_exp[37:32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic cache_write(input logic [5:0] a, input logic [31:0] d, input bit expect_mem,
                             output int stalls, output int acc_cyc);
    @(negedge CLK);
    cbus.WRITE = 1'b1; cbus.ADDRESS = a; cbus.WRITEDATA = d;
    if (expect_mem) exp_wr.push_back({a, d});
    stalls = 0;
    #1;
    while (cbus.BUSYWAIT && stalls < 100) begin
      @(negedge CLK); #1; stalls++;
    end
    acc_cyc = cyc + 1;
    @(posedge CLK); #1;
    cbus.WRITE = 1'b0;
  endtask

  task automatic cache_read(input logic [5:0] a, output logic [31:0] d, output int stalls,
                            output bit saw_mread, output int wr_at_done);
    @(negedge CLK);
    cbus.READ = 1'b1; cbus.ADDRESS = a;
    stalls = 0; saw_mread = 1'b0;
    #1;
    if (mbus.READ) saw_mread = 1'b1;
    while (cbus.BUSYWAIT && stalls < 200) begin
      @(negedge CLK); #1; stalls++;
      if (mbus.READ) saw_mread = 1'b1;
    end
    d = cbus.READDATA;
    wr_at_done = wr_count;
    @(posedge CLK); #1;
    cbus.READ = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 300 && (exp_wr.size() != 0 || !BUF_EMPTY); i++) @(negedge CLK);
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({mbus.READ, mbus.WRITE} !== 2'b00) begin failures++; $display("FAIL reset_m_req: got %b exp 00", {mbus.READ, mbus.WRITE}); end
    checks++; if (mbus.ADDRESS !== 6'h0) begin failures++; $display("FAIL reset_m_addr: got %h exp 00", mbus.ADDRESS); end
    checks++; if (mbus.WRITEDATA !== 32'h0) begin failures++; $display("FAIL reset_m_wdata: got %h exp 0", mbus.WRITEDATA); end
    checks++; if (cbus.READDATA !== 32'h0) begin failures++; $display("FAIL reset_c_rdata: got %h exp 0", cbus.READDATA); end
    checks++; if (BUF_EMPTY !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b exp 1", BUF_EMPTY); end
    checks++; if (cbus.BUSYWAIT !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b exp 0", cbus.BUSYWAIT); end
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic test_post_write();
    int st, ac;
    mem_lat = 5; force_busy = 1'b0;
    cache_write(6'h0A, 32'hDEADBEEF, 1'b1, st, ac);
    checks++; if (st !== 0) begin failures++; $display("FAIL post_accept_stall: got %0d exp 0", st); end
    checks++; if (mbus.WRITE !== 1'b0) begin failures++; $display("FAIL post_mwrite_early: got %b exp 0", mbus.WRITE); end
    @(posedge CLK); #1;
    checks++;
    if ({mbus.WRITE, mbus.ADDRESS, mbus.WRITEDATA} !== {1'b1, 6'h0A, 32'hDEADBEEF}) begin
      failures++; $display("FAIL post_mwrite: got %b %h %h exp 1 0a deadbeef", mbus.WRITE, mbus.ADDRESS, mbus.WRITEDATA);
    end
    checks++; if (BUF_EMPTY !== 1'b0) begin failures++; $display("FAIL post_busy_empty: got %b exp 0", BUF_EMPTY); end
    settle();
    checks++; if (exp_wr.size() != 0 || BUF_EMPTY !== 1'b1) begin failures++; $display("FAIL post_drain: left=%0d empty=%b exp 0 1", exp_wr.size(), BUF_EMPTY); end
  endtask

  task automatic test_full();
    int st, ac, st5, ac5;
    mem_lat = 3; force_busy = 1'b1;
    done_cyc.delete();
    for (int i = 1; i <= 4; i++) begin
      cache_write(6'(i), 32'h1000 + i, 1'b1, st, ac);
      checks++; if (st !== 0) begin failures++; $display("FAIL full_fill_stall[%0d]: got %0d exp 0", i, st); end
    end
    fork
      cache_write(6'h05, 32'h1005, 1'b1, st5, ac5);
      begin
        repeat (3) @(negedge CLK);
        #2;
        checks++; if (cbus.BUSYWAIT !== 1'b1) begin failures++; $display("FAIL full_busy: got %b exp 1", cbus.BUSYWAIT); end
        force_busy = 1'b0;
      end
    join
    checks++; if (st5 == 0 || st5 >= 100) begin failures++; $display("FAIL full_stall_count: got %0d exp 1..99", st5); end
    checks++;
    if (done_cyc.size() == 0 || ac5 != done_cyc[0] + 1) begin
      failures++; $display("FAIL full_accept_edge: got %0d exp %0d", ac5, (done_cyc.size() == 0) ? -1 : done_cyc[0] + 1);
    end
    settle();
    checks++; if (exp_wr.size() != 0) begin failures++; $display("FAIL full_drain_left: got %0d exp 0", exp_wr.size()); end
  endtask

  task automatic test_coalesce();
    int st, ac, w0;
    mem_lat = 2; force_busy = 1'b1;
    w0 = wr_count;
    cache_write(6'h06, 32'h66, 1'b1, st, ac);
    cache_write(6'h07, 32'h11, 1'b0, st, ac);
    cache_write(6'h07, 32'h22, 1'b1, st, ac);
    checks++; if (st !== 0) begin failures++; $display("FAIL coal_stall: got %0d exp 0", st); end
    cache_write(6'h08, 32'h88, 1'b1, st, ac);
    cache_write(6'h09, 32'h99, 1'b1, st, ac);
    checks++; if (st !== 0) begin failures++; $display("FAIL coal_count: stall %0d exp 0", st); end
    fork
      cache_write(6'h0C, 32'hCC, 1'b1, st, ac);
      begin
        repeat (2) @(negedge CLK);
        #2;
        checks++; if (cbus.BUSYWAIT !== 1'b1) begin failures++; $display("FAIL coal_full: got %b exp 1", cbus.BUSYWAIT); end
        force_busy = 1'b0;
      end
    join
    settle();
    checks++; if (wr_count - w0 != 5) begin failures++; $display("FAIL coal_writes: got %0d exp 5", wr_count - w0); end
  endtask

  task automatic test_back_to_back();
    int st, ac, w0;
    mem_lat = 2; force_busy = 1'b0;
    w0 = wr_count;
    cache_write(6'h10, 32'h1, 1'b0, st, ac);
    cache_write(6'h10, 32'h2, 1'b1, st, ac);
    checks++; if (st !== 0) begin failures++; $display("FAIL b2b_stall: got %0d exp 0", st); end
    settle();
    checks++; if (wr_count - w0 != 1) begin failures++; $display("FAIL b2b_writes: got %0d exp 1", wr_count - w0); end
  endtask

  task automatic test_read();
    int st, ac, rst, wat, w0;
    bit saw;
    logic [31:0] d, e;
    mem_lat = 2; force_busy = 1'b1;
    cache_write(6'h05, 32'hCAFEF00D, 1'b1, st, ac);
    cache_write(6'h0B, 32'h0000B0B0, 1'b1, st, ac);
    exp_rd.push_back(32'hCAFEF00D);
    cache_read(6'h05, d, rst, saw, wat);
    e = exp_rd.pop_front();
    checks++; if (d !== e) begin failures++; $display("FAIL rd_hit_data: got %h exp %h", d, e); end
    checks++; if (rst !== 0) begin failures++; $display("FAIL rd_hit_stall: got %0d exp 0", rst); end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL rd_hit_mread: got %b exp 0", saw); end
    w0 = wr_count;
    exp_rd.push_back({2{6'h30, 10'h35A}});
    fork
      cache_read(6'h30, d, rst, saw, wat);
      begin
        repeat (3) @(negedge CLK);
        #2 force_busy = 1'b0;
      end
    join
    e = exp_rd.pop_front();
    checks++; if (d !== e) begin failures++; $display("FAIL rd_miss_data: got %h exp %h", d, e); end
    checks++; if (saw !== 1'b1 || rst == 0 || rst >= 200) begin failures++; $display("FAIL rd_miss_mread: saw=%b stalls=%0d exp 1 1..199", saw, rst); end
    checks++; if (wat - w0 != 1) begin failures++; $display("FAIL rd_miss_bypass: drained %0d exp 1", wat - w0); end
    settle();
    checks++; if (exp_wr.size() != 0) begin failures++; $display("FAIL rd_drain_left: got %0d exp 0", exp_wr.size()); end
  endtask

  task automatic test_reset_drain();
    int st, ac, w0;
    mem_lat = 8; force_busy = 1'b0;
    cache_write(6'h20, 32'h12345678, 1'b0, st, ac);
    for (int i = 0; i < 20 && !mbus.WRITE; i++) @(negedge CLK);
    checks++; if (mbus.WRITE !== 1'b1) begin failures++; $display("FAIL rstd_start: got %b exp 1", mbus.WRITE); end
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    checks++; if ({mbus.READ, mbus.WRITE} !== 2'b00) begin failures++; $display("FAIL rstd_m_req: got %b exp 00", {mbus.READ, mbus.WRITE}); end
    checks++; if ({mbus.ADDRESS, mbus.WRITEDATA} !== 38'h0) begin failures++; $display("FAIL rstd_m_bus: got %h %h exp 0 0", mbus.ADDRESS, mbus.WRITEDATA); end
    checks++; if (cbus.READDATA !== 32'h0) begin failures++; $display("FAIL rstd_c_rdata: got %h exp 0", cbus.READDATA); end
    checks++; if (BUF_EMPTY !== 1'b1) begin failures++; $display("FAIL rstd_empty: got %b exp 1", BUF_EMPTY); end
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    w0 = wr_count;
    repeat (20) @(negedge CLK);
    checks++; if (wr_count != w0) begin failures++; $display("FAIL rstd_no_write: got %0d exp 0", wr_count - w0); end
    checks++; if (BUF_EMPTY !== 1'b1) begin failures++; $display("FAIL rstd_empty_after: got %b exp 1", BUF_EMPTY); end
  endtask

  initial begin
    cbus.READ = 1'b0; cbus.WRITE = 1'b0; cbus.ADDRESS = '0; cbus.WRITEDATA = '0;
    test_reset();
    test_post_write();
    test_full();
    test_coalesce();
    test_back_to_back();
    test_read();
    test_reset_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
endmodule
